hs4_rx_bridge: RTL and testbench
================================

Name: hs4_rx_bridge

Overview:
- Clocked consumer placed directly downstream of the asynchronous STG handshake stage.
- Accepts 4-phase bundled-data tokens: the STG's Rout drives this block's Rin, and this block's Ain drives the STG's Aout.
- Synchronises the request, captures the data, and buffers tokens in a small FIFO.
- Presents tokens to the synchronous core on a valid/ready interface, converting the self-timed pipeline output into clock-domain data.

Parameters:
- DW, 4, token data width; matches the STG data_out width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- SYNC_STAGES, 2, flops in the Rin synchroniser; at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Rin  input  1  4-phase request from the upstream STG (Rout); asynchronous to clk.
- data_in  input  DW  bundled data from the STG; stable whenever Rin=1.
- Ain  output  1  4-phase acknowledge to the STG (Aout); registered.
- out_valid  output  1  FIFO head holds a token.
- out_data  output  DW  FIFO head; first-word fall-through.
- out_ready  input  1  consumer accepts the head this cycle.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.
- stalled  output  1  request pending but FIFO full.

Behaviour:
- Reset (reset=0), asynchronous:
  - Ain=0, out_valid=0, out_data=0, level=0, stalled=0.
  - Synchroniser flops cleared; FSM in IDLE; FIFO pointers at 0.
- Protocol: 4-phase return-to-zero, Rin and Ain active-high:
  - Rin rises, then Ain rises, then Rin falls, then Ain falls.
  - One token per full cycle.
- Synchroniser: Rin passes through SYNC_STAGES flops to give rin_s. data_in is not synchronised; bundled-data guarantees it is stable while Rin=1.
- FSM states: IDLE and ACK.
  - IDLE, Ain=0:
    - If rin_s=1 and push is allowed: write data_in into the FIFO, go to ACK, Ain=1 from the next cycle.
    - If rin_s=1 and the FIFO is full with no pop this cycle: stay in IDLE with stalled=1. No data is lost; the STG simply waits.
  - ACK, Ain=1: when rin_s=0, go to IDLE with Ain=0. Stays in ACK while rin_s=1.
  - After Ain falls, a new capture requires rin_s=1 to be seen in IDLE. This excludes double capture.
- Latency, with SYNC_STAGES=2:
  - Rin rises before edge N; rin_s=1 after edge N+1; the capture and Ain=1 are registered at edge N+2.
  - out_valid=1 in the cycle after edge N+2 if the FIFO was empty.
  - Ain falls at edge M+2, where edge M is the first edge after Rin falls.
- Push condition: !full, or pop in the same cycle.
  - A simultaneous push and pop at full keeps level=DEPTH.
  - A simultaneous push and pop at empty: no pop (out_valid=0), push only.
- Pop: out_valid && out_ready. out_ready is ignored when out_valid=0.
- Pointers wrap modulo DEPTH. level changes by +1, -1, or 0 only.
- Reset mid-handshake (for example in ACK):
  - Ain drops immediately and buffered tokens are discarded.
  - The STG is reset from the same reset net. If Rin is still high after reset release, it is treated as a new token.
- stalled is combinational from registered state: (state==IDLE) && rin_s && full && !pop.

Decomposition:
- Shared package hs_pkg:
  - Default DW constant.
  - FSM state enum {IDLE, ACK}.
  - LEVEL_W function/constant.
- Sub-module hs_sync_fifo:
  - Parameterised by DW and DEPTH.
  - Ports: push, push_data, pop, head_data, empty, full, level.
- The synchroniser and FSM stay in the top module.

Test Plan:
- Single token: after reset release, Rin=1 with data_in=4'h1 and out_ready=1.
  - Ain rises 3 edges after Rin; out_data=4'h1 with out_valid=1 for 1 cycle.
  - Rin=0 gives Ain=0 3 edges later.
- Back-to-back tokens 4'h1, 4'h2, 4'h3 with out_ready=1:
  - Popped in order, no duplicates.
  - Ain pulses exactly 3 times; level never exceeds 1.
- Backpressure: out_ready=0, send 5 tokens (4'h1 to 4'h5) with DEPTH=4.
  - level=4 after 4 tokens; the 5th request leaves Ain=0 and stalled=1.
  - Raising out_ready pops 4'h1, then the 5th token is accepted; output order is 1..5.
- Full push/pop: with FIFO full and the 5th request pending, assert out_ready for exactly 1 cycle.
  - Push and pop happen in the same cycle; level stays 4.
  - stalled falls and Ain rises at the next edge.
- Reset mid-handshake: assert reset while in ACK with level=2.
  - Ain=0, out_valid=0, level=0 immediately, without waiting for a clock edge.
  - After release with Rin held at 1, exactly one new token is captured.
- Data stability: change data_in while Rin=0 between tokens.
  - The captured values equal only the data present while Rin=1.

Source files
------------

// File: rtl/hs4_rx_bridge_pkg.sv
// Shared types and sizing helpers for the 4-phase receive bridge.
package hs_pkg;

    localparam int DW_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_e;

    // Occupancy needs one extra bit so that a full FIFO (level == DEPTH) is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hs4_rx_bridge_fifo.sv
// Small first-word fall-through FIFO; the head reads as zero while empty.
module hs_sync_fifo
    import hs_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DW-1:0]             push_data,
    input  logic                      pop,
    output logic [DW-1:0]             head_data,
    output logic                      empty,
    output logic                      full,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] count_q;
    logic [LW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == LW'(DEPTH));
    assign level     = count_q;
    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/hs4_rx_bridge.sv
// Clocked receiver for 4-phase bundled-data tokens: synchronises Rin, captures
// data_in into a FIFO and returns Ain, presenting tokens on a valid/ready port.
module hs4_rx_bridge
    import hs_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Rin,
    input  logic [DW-1:0]             data_in,
    output logic                      Ain,
    output logic                      out_valid,
    output logic [DW-1:0]             out_data,
    input  logic                      out_ready,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      stalled
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rin_s;
    hs_state_e              state_q;
    hs_state_e              state_d;
    logic                   push;
    logic                   pop;
    logic                   push_ok;
    logic                   fifo_empty;
    logic                   fifo_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], Rin};
    end

    assign rin_s     = sync_q[SYNC_STAGES-1];
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    // A full FIFO can still take a token when the head leaves in the same cycle.
    assign push_ok   = !fifo_full || pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rin_s && push_ok) state_d = ACK;
            ACK:     if (!rin_s)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ain is the state register itself, so it is glitch-free toward the STG.
    always_comb begin
        Ain     = (state_q == ACK);
        push    = (state_q == IDLE) && rin_s && push_ok;
        stalled = (state_q == IDLE) && rin_s && fifo_full && !pop;
    end

    hs_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (data_in),
        .pop       (pop),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

endmodule

// File: tb/tb_hs4_rx_bridge.sv
// Directed bench for hs4_rx_bridge: cycle table for single tokens plus handshake sequences.
module tb_hs4_rx_bridge;

    logic       clk;
    logic       reset;
    logic       Rin;
    logic [3:0] data_in;
    logic       Ain;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic [2:0] level;
    logic       stalled;

    int vectors     = 0;
    int miscompares = 0;

    bit         mon_en   = 0;
    logic       ain_prev = 0;
    int         pulses   = 0;
    int         max_lvl  = 0;
    logic [3:0] got[$];

    typedef struct packed {
        logic       rin;
        logic [3:0] din;
        logic       rdy;
        logic       ain;
        logic       vld;
        logic [3:0] dout;
        logic [2:0] lvl;
        logic       stl;
    } vec_t;

    vec_t tbl[16];

    hs4_rx_bridge #(
        .DW          (4),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Rin       (Rin),
        .data_in   (data_in),
        .Ain       (Ain),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .stalled   (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (Ain && !ain_prev) pulses++;
            ain_prev = Ain;
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for Ain to reach v, then returns 1 time unit after a rising edge.
    task automatic wait_ain(input logic v, input string name);
        bit ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (Ain === v) begin
                ok = 1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_token(input logic [3:0] d);
        data_in = d;
        Rin     = 1'b1;
        wait_ain(1'b1, "ain_rise");
        Rin     = 1'b0;
        data_in = ~d;
        wait_ain(1'b0, "ain_fall");
    endtask

    initial begin
        //             rin din   rdy  ain vld dout  lvl   stl
        tbl[0]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 4'h1, 3'd1, 1'b0};
        tbl[4]  = '{1'b0, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'hC, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[7]  = '{1'b0, 4'h9, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[9]  = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[10] = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[11] = '{1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 4'h2, 3'd1, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[13] = '{1'b0, 4'h6, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[14] = '{1'b0, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 3'd0, 1'b0};

        reset     = 1'b0;
        Rin       = 1'b0;
        data_in   = 4'h0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ain", 32'(Ain), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_stalled", 32'(stalled), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Cycle table: inputs set just after an edge, outputs checked mid-cycle.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            Rin       = tbl[i].rin;
            data_in   = tbl[i].din;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d_ain", i), 32'(Ain), 32'(tbl[i].ain));
            chk($sformatf("row%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("row%0d_data", i), 32'(out_data), 32'(tbl[i].dout));
            chk($sformatf("row%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("row%0d_stalled", i), 32'(stalled), 32'(tbl[i].stl));
        end
        @(posedge clk);
        #1;

        // Back-to-back tokens with a ready consumer.
        out_ready = 1'b1;
        got.delete();
        pulses  = 0;
        max_lvl = 0;
        mon_en  = 1;
        send_token(4'h1);
        send_token(4'h2);
        send_token(4'h3);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_count", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            chk($sformatf("b2b_tok%0d", i), 32'(got[i]), 32'(i + 1));
        chk("b2b_pulses", 32'(pulses), 32'd3);
        chk("b2b_maxlvl", 32'(max_lvl <= 1), 32'd1);

        // Backpressure: fill the FIFO, then hold a fifth request.
        out_ready = 1'b0;
        got.delete();
        for (int t = 1; t <= 4; t++) send_token(4'(t));
        chk("bp_level4", 32'(level), 32'd4);
        data_in = 4'h5;
        Rin     = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_ain_low", 32'(Ain), 32'd0);
        chk("bp_stalled", 32'(stalled), 32'd1);
        chk("bp_level", 32'(level), 32'd4);

        // One-cycle ready at full: push and pop share the edge.
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fp_stalled_drop", 32'(stalled), 32'd0);
        chk("fp_head", 32'(out_data), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("fp_level", 32'(level), 32'd4);
        chk("fp_ain", 32'(Ain), 32'd1);
        chk("fp_stalled", 32'(stalled), 32'd0);
        Rin = 1'b0;
        wait_ain(1'b0, "fp_ain_fall");
        out_ready = 1'b1;
        begin
            bit drained = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (level === 3'd0) begin
                    drained = 1;
                    break;
                end
            end
            chk("bp_drained", 32'(drained), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("bp_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("bp_tok%0d", i), 32'(got[i]), 32'(i + 1));

        // Reset while in ACK with two tokens buffered.
        out_ready = 1'b0;
        send_token(4'h6);
        data_in = 4'h7;
        Rin     = 1'b1;
        wait_ain(1'b1, "mr_ain_rise");
        chk("mr_level2", 32'(level), 32'd2);
        #2;
        reset  = 1'b0;
        pulses = 0;
        #1;
        chk("mr_ain", 32'(Ain), 32'd0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_level", 32'(level), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("mr_new_pulse", 32'(pulses), 32'd1);
        chk("mr_new_level", 32'(level), 32'd1);
        chk("mr_new_data", 32'(out_data), 32'd7);
        chk("mr_new_ain", 32'(Ain), 32'd1);
        Rin = 1'b0;
        wait_ain(1'b0, "mr_ain_fall");
        repeat (3) @(posedge clk);
        #1;
        chk("mr_single_level", 32'(level), 32'd1);
        chk("mr_single_pulse", 32'(pulses), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
